// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for an external combinational 8-bit ALU: accepts one
// instruction, drives the ALU from its registers, then writes result and flags back.
module alu_exec_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [7:0]  ACC_RST = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [7:0]       in_imm,
  output logic [3:0]       alu_op,
  output logic             alu_s30,
  output logic             alu_s40,
  output logic             alu_cin,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [7:0]       alu_imm,
  input  logic [7:0]       alu_out,
  input  logic [3:0]       alu_flags,
  output logic [7:0]       acc,
  output logic [7:0]       breg,
  output logic [3:0]       flags,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CARRY  = 1;

  localparam logic [1:0] DST_ACC    = 2'b00;
  localparam logic [1:0] DST_BREG   = 2'b01;
  localparam logic [1:0] DST_CMP    = 2'b10;
  localparam logic [1:0] DST_ACC_NF = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       s30;
    logic       s40;
    logic [1:0] dest;
  } instr_t;

  state_t              state_q, state_d;
  instr_t              ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [FLAG_W-1:0]   flg_q, flg_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   breg_q, breg_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  instr_t              instr;

  assign instr = instr_t'(in_op);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, writeback and ALU control decode
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    res_d   = res_q;
    flg_d   = flg_q;
    acc_d   = acc_q;
    breg_d  = breg_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          ctrl_d  = instr;
          imm_d   = in_imm;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        flg_d   = alu_flags;
        state_d = WB;
      end
      WB: begin
        case (ctrl_q.dest)
          DST_ACC: begin
            acc_d   = res_q;
            flags_d = flg_q;
          end
          DST_BREG: begin
            breg_d  = res_q;
            flags_d = flg_q;
          end
          DST_CMP:    flags_d = flg_q;
          DST_ACC_NF: acc_d   = res_q;
        endcase
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        ctrl_d  = '0;
        imm_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered from the next state so it matches state==IDLE exactly
    ready_d = (state_d == IDLE);
  end

  // Datapath and control registers; a reset mid-instruction drops it without writeback
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      acc_q   <= ACC_RST;
      breg_q  <= ACC_RST;
      flags_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      acc_q   <= acc_d;
      breg_q  <= breg_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready = ready_q;
  assign alu_op   = ctrl_q.op;
  assign alu_s30  = ctrl_q.s30;
  assign alu_s40  = ctrl_q.s40;
  assign alu_imm  = imm_q;
  assign alu_a    = acc_q;
  assign alu_b    = breg_q;
  assign alu_cin  = flags_q[CARRY];
  assign acc      = acc_q;
  assign breg     = breg_q;
  assign flags    = flags_q;
  assign done     = done_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: a behavioural ALU drives the DUT, an
// architectural model predicts each writeback, and a monitor checks every done pulse.
module tb_alu_exec_ctrl;

  localparam int unsigned CNT_W   = 2;
  localparam logic [7:0]  ACC_RST = 8'h3C;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_op = 8'h00;
  logic [7:0]       in_imm = 8'h00;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic             alu_s30, alu_s40, alu_cin;
  logic [7:0]       alu_a, alu_b, alu_imm, alu_out;
  logic [3:0]       alu_flags;
  logic [7:0]       acc, breg;
  logic [3:0]       flags;
  logic             done;
  logic [CNT_W-1:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] acc;
    logic [7:0] breg;
    logic [3:0] flags;
    int         cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_acc, m_breg;
  logic [3:0] m_flags;
  int         m_cnt;

  // Behavioural ALU: returns {result, OddParity, Positive, Cout, Zero}
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic s30,
                                         input logic s40, input logic cin,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] imm);
    logic [7:0] x, y, res;
    logic [8:0] r;
    logic       c;
    x = s30 ? b : a;
    y = s40 ? imm : b;
    c = cin;
    r = 9'd0;
    case (op)
      4'h0: begin r = 9'd0; c = 1'b0; end
      4'h1: r = {1'b0, x & y};
      4'h2: r = {1'b0, x | y};
      4'h3: r = {1'b0, y};
      4'h4: begin r = {1'b0, x} + 9'd1; c = r[8]; end
      4'h5: begin r = {1'b0, x} - 9'd1; c = r[8]; end
      4'h6: r = {1'b0, x ^ y};
      4'h7: r = {1'b0, ~x};
      4'h8: begin r = {1'b0, x} + {1'b0, y}; c = r[8]; end
      4'h9: begin r = {1'b0, x} - {1'b0, y}; c = r[8]; end
      4'hA: begin r = {1'b0, x} + {1'b0, y} + 9'(cin); c = r[8]; end
      4'hB: begin r = {1'b0, x} - {1'b0, y} - 9'(cin); c = r[8]; end
      4'hC: begin r = {x, 1'b0}; c = x[7]; end
      4'hD: begin r = {1'b0, cin, x[7:1]}; c = x[0]; end
      4'hE: begin r = {x, cin}; c = x[7]; end
      default: r = {1'b0, x};
    endcase
    res = r[7:0];
    return {res, ^res, ~res[7], c, (res == 8'h00)};
  endfunction

  assign {alu_out, alu_flags} = alu_fn(alu_op, alu_s30, alu_s40, alu_cin, alu_a, alu_b, alu_imm);

  alu_exec_ctrl #(.CNT_W(CNT_W), .ACC_RST(ACC_RST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .alu_op(alu_op), .alu_s30(alu_s30),
    .alu_s40(alu_s40), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b),
    .alu_imm(alu_imm), .alu_out(alu_out), .alu_flags(alu_flags), .acc(acc),
    .breg(breg), .flags(flags), .done(done), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc   = ACC_RST;
    m_breg  = ACC_RST;
    m_flags = 4'h0;
    m_cnt   = 0;
    sb_q.delete();
  endtask

  // Architectural effect of one accepted instruction
  task automatic model_accept(input logic [7:0] op, input logic [7:0] imm);
    logic [11:0] r;
    exp_t        e;
    r = alu_fn(op[7:4], op[3], op[2], m_flags[1], m_acc, m_breg, imm);
    case (op[1:0])
      2'b00: begin m_acc = r[11:4]; m_flags = r[3:0]; end
      2'b01: begin m_breg = r[11:4]; m_flags = r[3:0]; end
      2'b10: m_flags = r[3:0];
      default: m_acc = r[11:4];
    endcase
    m_cnt++;
    e.acc = m_acc; e.breg = m_breg; e.flags = m_flags; e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  // Issue from IDLE at a negedge; returns at the negedge of the done cycle
  task automatic issue(input logic [7:0] op, input logic [7:0] imm, input bit bp);
    logic cin_exp;
    chk("ready_idle", 32'(in_ready), 32'd1);
    cin_exp  = m_flags[1];
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    @(posedge clk);
    model_accept(op, imm);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ready_exec", 32'(in_ready), 32'd0);
    chk("cin_exec", 32'(alu_cin), 32'(cin_exp));
    chk("aluop_exec", 32'(alu_op), 32'(op[7:4]));
    chk("imm_exec", 32'(alu_imm), 32'(imm));
    in_valid = bp;
    in_op    = bp ? 8'h00 : 8'($urandom);
    in_imm   = 8'($urandom);
    @(negedge clk);
    chk("ready_wb", 32'(in_ready), 32'd0);
    chk("done_wb", 32'(done), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_done", 32'(in_ready), 32'd1);
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got done=1 expected no outstanding op at %0t", $time);
      end else begin
        exp_t             e;
        logic [CNT_W-1:0] c;
        e = sb_q.pop_front();
        c = CNT_W'(e.cnt);
        chk("wb_acc", 32'(acc), 32'(e.acc));
        chk("wb_breg", 32'(breg), 32'(e.breg));
        chk("wb_flags", 32'(flags), 32'(e.flags));
        chk("wb_count", 32'(op_count), 32'(c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_acc", 32'(acc), 32'(ACC_RST));
    chk("rst_breg", 32'(breg), 32'(ACC_RST));
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_aluop", 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sequence from the architectural examples
    issue(8'h34, 8'hFF, 1'b0);
    chk("load_acc", 32'(acc), 32'h00FF);
    chk("load_flags", 32'(flags), 32'b0000);
    chk("load_count", 32'(op_count), 32'd1);
    issue(8'h40, 8'h00, 1'b0);
    chk("inc_acc", 32'(acc), 32'h0000);
    chk("inc_flags", 32'(flags), 32'b0111);
    issue(8'h35, 8'h01, 1'b0);
    chk("loadb_breg", 32'(breg), 32'h0001);
    chk("carry_kept", 32'(flags[1]), 32'd1);
    issue(8'hA0, 8'h00, 1'b0);
    chk("adc_acc", 32'(acc), 32'h0002);
    chk("adc_flags", 32'(flags), 32'b1100);
    chk("count_wrap", 32'(op_count), 32'd0);
    issue(8'h34, 8'h05, 1'b0);
    issue(8'h35, 8'h05, 1'b0);
    issue(8'h92, 8'h00, 1'b1);
    chk("cmp_acc", 32'(acc), 32'h0005);
    chk("cmp_breg", 32'(breg), 32'h0005);
    chk("cmp_flags", 32'(flags), 32'b0101);

    // Reset during EXEC aborts the instruction
    in_valid = 1'b1;
    in_op    = 8'h34;
    in_imm   = 8'h77;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("abort_acc", 32'(acc), 32'(ACC_RST));
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done), 32'd0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
